// File: rtl/detector_sentido.sv
// Direction detector for a two-beam barrier: synchronizes and debounces both
// photo-sensors, then tracks the beam-blocking order to emit entry/exit pulses.
module detector_sentido #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic       entrada,
  output logic       salida,
  output logic       ocupado,
  output logic [2:0] estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    E1         = 3'd1,
    E2         = 3'd2,
    E3         = 3'd3,
    S1         = 3'd4,
    S2         = 3'd5,
    S3         = 3'd6,
    WAIT_CLEAR = 3'd7
  } state_t;

  logic [1:0]       sync_a_q, sync_a_d;
  logic [1:0]       sync_b_q, sync_b_d;
  logic             deb_a_q, deb_a_d;
  logic             deb_b_q, deb_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  state_t           state_q, state_d;
  logic             entrada_q, entrada_d;
  logic             salida_q, salida_d;
  logic             ocupado_q, ocupado_d;

  // Synchronizer and debouncer stage: the count tracks how long the synchronized
  // bit has disagreed with the accepted level; reaching the limit accepts it.
  always_comb begin
    sync_a_d = {sync_a_q[0], sensor_a};
    sync_b_d = {sync_b_q[0], sensor_b};

    deb_a_d = deb_a_q;
    cnt_a_d = '0;
    if (sync_a_q[1] != deb_a_q) begin
      if (cnt_a_q == CNT_LAST) begin
        deb_a_d = ~deb_a_q;
      end else begin
        cnt_a_d = cnt_a_q + CNT_ONE;
      end
    end

    deb_b_d = deb_b_q;
    cnt_b_d = '0;
    if (sync_b_q[1] != deb_b_q) begin
      if (cnt_b_q == CNT_LAST) begin
        deb_b_d = ~deb_b_q;
      end else begin
        cnt_b_d = cnt_b_q + CNT_ONE;
      end
    end
  end

  // Sequence stage: reacts to the debounced pair; pulses are registered so they
  // appear in the cycle right after the completing edge.
  always_comb begin
    state_d   = state_q;
    entrada_d = 1'b0;
    salida_d  = 1'b0;
    ocupado_d = deb_a_d | deb_b_d;
    case (state_q)
      IDLE: begin
        case ({deb_a_q, deb_b_q})
          2'b10:   state_d = E1;
          2'b01:   state_d = S1;
          2'b11:   state_d = WAIT_CLEAR;
          default: state_d = IDLE;
        endcase
      end
      E1: begin
        case ({deb_a_q, deb_b_q})
          2'b11:   state_d = E2;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = WAIT_CLEAR;
          default: state_d = E1;
        endcase
      end
      E2: begin
        case ({deb_a_q, deb_b_q})
          2'b01:   state_d = E3;
          2'b10:   state_d = E1;
          2'b00:   state_d = IDLE;
          default: state_d = E2;
        endcase
      end
      E3: begin
        case ({deb_a_q, deb_b_q})
          2'b00: begin
            state_d   = IDLE;
            entrada_d = 1'b1;
          end
          2'b11:   state_d = E2;
          2'b10:   state_d = WAIT_CLEAR;
          default: state_d = E3;
        endcase
      end
      S1: begin
        case ({deb_a_q, deb_b_q})
          2'b11:   state_d = S2;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = WAIT_CLEAR;
          default: state_d = S1;
        endcase
      end
      S2: begin
        case ({deb_a_q, deb_b_q})
          2'b10:   state_d = S3;
          2'b01:   state_d = S1;
          2'b00:   state_d = IDLE;
          default: state_d = S2;
        endcase
      end
      S3: begin
        case ({deb_a_q, deb_b_q})
          2'b00: begin
            state_d  = IDLE;
            salida_d = 1'b1;
          end
          2'b11:   state_d = S2;
          2'b01:   state_d = WAIT_CLEAR;
          default: state_d = S3;
        endcase
      end
      WAIT_CLEAR: begin
        if ({deb_a_q, deb_b_q} == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      deb_a_q   <= 1'b0;
      deb_b_q   <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      state_q   <= IDLE;
      entrada_q <= 1'b0;
      salida_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      deb_a_q   <= deb_a_d;
      deb_b_q   <= deb_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      state_q   <= state_d;
      entrada_q <= entrada_d;
      salida_q  <= salida_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign entrada = entrada_q;
  assign salida  = salida_q;
  assign ocupado = ocupado_q;
  assign estado  = state_q;

endmodule

// File: doc/detector_sentido.md
DETECTOR_SENTIDO -- requirements
Module: detector_sentido

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 120000, is the number of consecutive stable samples needed to accept a sensor level (10 ms at 12 MHz); legal range 1..2^20.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 sensor_a  input  1  raw, asynchronous, bouncy photo-barrier A (outer side); 1 = beam blocked.
REQ-005 sensor_b  input  1  raw, asynchronous, bouncy photo-barrier B (inner side); 1 = beam blocked.
REQ-006 entrada  output  1  registered one-cycle pulse marking one completed entry; drives the downstream occupancy counter's Z1.
REQ-007 salida  output  1  registered one-cycle pulse marking one completed exit; drives the downstream occupancy counter's Z0.
REQ-008 ocupado  output  1  registered; 1 while either debounced sensor is 1.
REQ-009 estado  output  3  current FSM state code (debug).

Function
REQ-010 Each sensor passes through a 2-flop synchronizer, then an independent debouncer.
REQ-011 Debouncer: the counter increments on each edge where the synchronized bit differs from the debounced bit; it clears on any edge where they are equal; the debounced bit toggles and the counter clears on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-012 Counter width is clog2(DEBOUNCE_CYCLES+1) bits; it never wraps.
REQ-013 A raw level held stable appears on the debounced bit exactly DEBOUNCE_CYCLES+2 edges after the change; the FSM reacts on the following edge.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES synchronized samples leave the debounced bit unchanged.
REQ-015 State codes: IDLE=0, E1=1, E2=2, E3=3, S1=4, S2=5, S3=6, WAIT_CLEAR=7; (a,b) denotes the debounced pair.
REQ-016 IDLE: (1,0)->E1; (0,1)->S1; (1,1)->WAIT_CLEAR; (0,0)->stay.
REQ-017 E1: (1,1)->E2; (0,0)->IDLE (abort, no pulse); (0,1)->WAIT_CLEAR; (1,0)->stay.
REQ-018 E2: (0,1)->E3; (1,0)->E1 (back-out); (0,0)->IDLE (no pulse); (1,1)->stay.
REQ-019 E3: (0,0)->IDLE and assert entrada; (1,1)->E2; (1,0)->WAIT_CLEAR; (0,1)->stay.
REQ-020 S1/S2/S3 mirror E1/E2/E3 with a and b swapped; S3 on (0,0)->IDLE and assert salida.
REQ-021 WAIT_CLEAR: (0,0)->IDLE with no pulse; otherwise stay.
REQ-022 entrada/salida are 1 only during the first cycle after the completing edge; at all other times they are 0.
REQ-023 entrada and salida are never 1 in the same cycle; back-to-back vehicles produce separate pulses at least 2 cycles apart.
REQ-024 Only the full sequence 00-10-11-01-00 (entry) or 00-01-11-10-00 (exit) produces a pulse; partial, reversed or aborted sequences produce none.

Reset
REQ-025 When rst=1 at an edge, synchronizers, debounced bits and counters go to 0, state goes to IDLE, and entrada, salida and ocupado go to 0; estado=0.
REQ-026 Reset overrides all other activity, including a completing edge; an in-progress sequence is discarded with no pulse.
REQ-027 After reset, sensors still blocked re-enter via debounce; a vehicle mid-barrier that is seen as (1,1) goes to WAIT_CLEAR.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Entry: drive A=1; then B=1; then A=0; then B=0, each held 20 cycles -> exactly one entrada pulse, one cycle wide, and no salida; estado visits 1,2,3,0.
REQ-029 Exit: drive the mirror sequence B, A, B-release, A-release -> exactly one salida pulse and no entrada; estado visits 4,5,6,0.
REQ-030 Bounce: toggle A every 2 cycles for 30 cycles, then hold A=1 -> the debounced A rises exactly 6 edges after the final stable edge; there is one E1 entry and no pulse.
REQ-031 Abort/back-out: drive A=1, B=1, B=0, A=0 -> estado goes 1,2,1,0 and no pulse is produced.
REQ-032 Illegal jump: raise A and B on the same cycle -> WAIT_CLEAR (7); releasing both -> IDLE with no pulse.
REQ-033 Reset mid-sequence: assert rst in E3 on the same edge that (0,0) arrives -> no entrada; all outputs are 0 the next cycle.
